// File: rtl/ccip_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// ccip_mem_responder_pkg
// Shared types for the CCI-P host-memory responder: the subset of CCI-P
// request/response encodings the responder understands, the read-response
// FSM state type, the queued read-request record and small decode helpers.
// ----------------------------------------------------------------------------
package ccip_mem_responder_pkg;

    // CCI-P field types (subset used by the responder)
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [1:0]   t_ccip_clNum;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1
    } t_ccip_rspType;

    typedef struct packed {
        t_ccip_clAddr address;
        t_ccip_clLen  cl_len;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_clAddr address;
        logic         sop;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_rspType resp_type;
        t_ccip_clNum   cl_num;
        t_ccip_mdata   mdata;
    } t_ccip_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_RspMemHdr hdr;
        t_ccip_clData    data;
        logic            rspValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_RspMemHdr hdr;
        logic            rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    // Read-response FSM states
    typedef enum logic [1:0] {
        S_RSP_IDLE  = 2'd0,
        S_RSP_WAIT  = 2'd1,
        S_RSP_BURST = 2'd2
    } t_rsp_state;

    // Queued read request
    typedef struct packed {
        t_ccip_clAddr address;
        t_ccip_clLen  cl_len;
        t_ccip_mdata  mdata;
    } t_rd_req;

    // Number of response beats for a read length encoding
    function automatic logic [2:0] beats_of(input t_ccip_clLen cl_len);
        case (cl_len)
            eCL_LEN_2: beats_of = 3'd2;
            eCL_LEN_4: beats_of = 3'd4;
            default:   beats_of = 3'd1;
        endcase
    endfunction

    // Multi-line reads must start on a line boundary of their own size
    function automatic logic is_misaligned(input t_ccip_clAddr address,
                                           input t_ccip_clLen  cl_len);
        case (cl_len)
            eCL_LEN_2: is_misaligned = (address[0] != 1'b0);
            eCL_LEN_4: is_misaligned = (address[1:0] != 2'b00);
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ccip_mem_responder_fifo.sv
// ----------------------------------------------------------------------------
// ccip_req_fifo
// Synchronous FIFO of queued read requests (t_rd_req).
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_data_i    enqueue request (accepted when not full, or when
//                          a pop happens in the same cycle)
//   pop_i, pop_data_o      dequeue; pop_data_o shows the head entry
//   count_o                current occupancy (0..DEPTH)
//   full_o, empty_o        occupancy flags
// ----------------------------------------------------------------------------
module ccip_req_fifo
    import ccip_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  t_rd_req                  push_data_i,
    input  logic                     pop_i,
    output t_rd_req                  pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    t_rd_req            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == {CNT_W{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok_s = push_i & (~full_o | pop_i);
    assign pop_ok_s  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_W'(1'b1);
                2'b01:   count_q <= count_q - CNT_W'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage (contents need no reset; occupancy gates visibility)
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ccip_mem_responder.sv
// ----------------------------------------------------------------------------
// ccip_mem_responder
// Host-memory stand-in for the far end of a CCI-P link. Read requests (c0)
// are queued and answered from a line-addressed RAM after a fixed latency,
// 1/2/4 beats per request, in request order. Write requests (c1) commit at
// acceptance and are acknowledged on the following cycle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   ccip_c0_tx          read requests (valid, address, cl_len, mdata)
//   ccip_c1_tx          write requests (valid, address, sop, mdata, data)
//   ccip_rx             almost-full flags, c0 read beats, c1 write acks
//   err_oor             sticky: address outside the memory window
//   err_align           sticky: misaligned multi-line read
//   err_overflow        sticky: read request dropped on a full queue
// ----------------------------------------------------------------------------
module ccip_mem_responder
    import ccip_mem_responder_pkg::*;
#(
    parameter int unsigned  MEM_LINES      = 1024,
    parameter t_ccip_clAddr BASE_CL_ADDR   = 42'd0,
    parameter int unsigned  RD_FIFO_DEPTH  = 8,
    parameter int unsigned  ALM_FULL_SLACK = 2,
    parameter int unsigned  RD_LATENCY     = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  t_if_ccip_c0_Tx ccip_c0_tx,
    input  t_if_ccip_c1_Tx ccip_c1_tx,
    output t_if_ccip_Rx    ccip_rx,
    output logic           err_oor,
    output logic           err_align,
    output logic           err_overflow
);

    localparam int unsigned IDX_W   = $clog2(MEM_LINES);
    localparam int unsigned CNT_W   = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int unsigned LAT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int unsigned ALM_THR = RD_FIFO_DEPTH - ALM_FULL_SLACK;

    // Request queue
    t_rd_req            push_req_s;
    t_rd_req            fifo_head_s;
    logic               fifo_pop_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // Response FSM
    t_rsp_state         state_q, state_d;
    logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]         beat_q, beat_d;
    t_rd_req            rd_req_q, rd_req_d;
    logic [1:0]         last_beat_s;
    logic               beat_issue_s;

    // Memory addressing
    t_ccip_clAddr       rd_line_s;
    t_ccip_clAddr       wr_line_s;
    logic               rd_oor_s;
    logic               wr_oor_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic [IDX_W-1:0]   wr_idx_s;
    t_ccip_clData       mem_q [MEM_LINES];
    t_ccip_clData       rd_data_q;

    // Registered response fields
    logic               c0_vld_q;
    t_ccip_clNum        c0_num_q;
    t_ccip_mdata        c0_mdata_q;
    logic               c1_vld_q;
    t_ccip_rspType      c1_type_q;
    t_ccip_mdata        c1_mdata_q;
    logic               c0_alm_q;
    logic               c1_alm_q;
    logic               err_oor_q;
    logic               err_align_q;
    logic               err_overflow_q;

    // Writes are always single-line, so sop carries no information here
    logic               unused_sop_s;
    assign unused_sop_s = ccip_c1_tx.hdr.sop;

    assign push_req_s = '{address: ccip_c0_tx.hdr.address,
                          cl_len:  ccip_c0_tx.hdr.cl_len,
                          mdata:   ccip_c0_tx.hdr.mdata};

    ccip_req_fifo #(
        .DEPTH (RD_FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (ccip_c0_tx.valid),
        .push_data_i (push_req_s),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (fifo_head_s),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Line index is relative to the window base; anything below the base
    // wraps to a huge value and lands in the out-of-range check as well.
    assign rd_line_s = rd_req_q.address + t_ccip_clAddr'(beat_q) - BASE_CL_ADDR;
    assign wr_line_s = ccip_c1_tx.hdr.address - BASE_CL_ADDR;
    assign rd_oor_s  = (rd_line_s >= t_ccip_clAddr'(MEM_LINES));
    assign wr_oor_s  = (wr_line_s >= t_ccip_clAddr'(MEM_LINES));
    assign rd_idx_s  = rd_line_s[IDX_W-1:0];
    assign wr_idx_s  = wr_line_s[IDX_W-1:0];

    assign last_beat_s = 2'(beats_of(rd_req_q.cl_len) - 3'd1);

    // Response FSM next-state: pop in IDLE, wait RD_LATENCY-1 cycles, then
    // issue one RAM read per cycle; the beat becomes visible one edge later,
    // which places the first beat exactly RD_LATENCY edges after the pop.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        beat_d       = beat_q;
        rd_req_d     = rd_req_q;
        fifo_pop_s   = 1'b0;
        beat_issue_s = 1'b0;
        case (state_q)
            S_RSP_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    rd_req_d   = fifo_head_s;
                    wait_cnt_d = {LAT_W{1'b0}};
                    beat_d     = 2'd0;
                    if (RD_LATENCY > 1) begin
                        state_d = S_RSP_WAIT;
                    end else begin
                        state_d = S_RSP_BURST;
                    end
                end else begin
                    state_d = S_RSP_IDLE;
                end
            end
            S_RSP_WAIT: begin
                if (wait_cnt_q == LAT_W'(RD_LATENCY - 2)) begin
                    state_d = S_RSP_BURST;
                end else begin
                    wait_cnt_d = wait_cnt_q + LAT_W'(1'b1);
                end
            end
            S_RSP_BURST: begin
                beat_issue_s = 1'b1;
                if (beat_q == last_beat_s) begin
                    state_d = S_RSP_IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: begin
                state_d = S_RSP_IDLE;
            end
        endcase
    end

    // Response FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RSP_IDLE;
            wait_cnt_q <= {LAT_W{1'b0}};
            beat_q     <= 2'd0;
            rd_req_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            rd_req_q   <= rd_req_d;
        end
    end

    // RAM write port; out-of-window writes are dropped
    always_ff @(posedge clk) begin
        if (ccip_c1_tx.valid && !wr_oor_s) begin
            mem_q[wr_idx_s] <= ccip_c1_tx.data;
        end
    end

    // Registered RAM read port. Sampling mem_q with non-blocking semantics
    // gives read-before-write when a same-edge write hits the same line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (beat_issue_s) begin
            if (rd_oor_s) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= mem_q[rd_idx_s];
            end
        end
    end

    // Response headers, almost-full flags and sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0_vld_q       <= 1'b0;
            c0_num_q       <= 2'd0;
            c0_mdata_q     <= 16'd0;
            c1_vld_q       <= 1'b0;
            c1_type_q      <= eRSP_RDLINE;  // encoding 0: header reads all-zero
            c1_mdata_q     <= 16'd0;
            c0_alm_q       <= 1'b0;
            c1_alm_q       <= 1'b1;         // writers are held off while in reset
            err_oor_q      <= 1'b0;
            err_align_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            c0_vld_q <= beat_issue_s;
            if (beat_issue_s) begin
                c0_num_q   <= beat_q;
                c0_mdata_q <= rd_req_q.mdata;
            end
            c1_vld_q <= ccip_c1_tx.valid;
            if (ccip_c1_tx.valid) begin
                c1_type_q  <= eRSP_WRLINE;
                c1_mdata_q <= ccip_c1_tx.hdr.mdata;
            end
            c0_alm_q       <= (fifo_count_s >= CNT_W'(ALM_THR));
            c1_alm_q       <= 1'b0;
            err_oor_q      <= err_oor_q
                              | (beat_issue_s & rd_oor_s)
                              | (ccip_c1_tx.valid & wr_oor_s);
            err_align_q    <= err_align_q
                              | (ccip_c0_tx.valid
                                 & is_misaligned(ccip_c0_tx.hdr.address, ccip_c0_tx.hdr.cl_len));
            err_overflow_q <= err_overflow_q
                              | (ccip_c0_tx.valid & fifo_full_s & ~fifo_pop_s);
        end
    end

    // Output struct assembly from registered fields
    always_comb begin
        ccip_rx                  = '0;
        ccip_rx.c0TxAlmFull      = c0_alm_q;
        ccip_rx.c1TxAlmFull      = c1_alm_q;
        ccip_rx.c0.rspValid      = c0_vld_q;
        ccip_rx.c0.hdr.resp_type = eRSP_RDLINE;
        ccip_rx.c0.hdr.cl_num    = c0_num_q;
        ccip_rx.c0.hdr.mdata     = c0_mdata_q;
        ccip_rx.c0.data          = rd_data_q;
        ccip_rx.c1.rspValid      = c1_vld_q;
        ccip_rx.c1.hdr.resp_type = c1_type_q;
        ccip_rx.c1.hdr.cl_num    = 2'd0;
        ccip_rx.c1.hdr.mdata     = c1_mdata_q;
    end

    assign err_oor      = err_oor_q;
    assign err_align    = err_align_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_ccip_mem_responder
// Directed bench for ccip_mem_responder. u_dut uses default parameters;
// u_dut_slow uses RD_LATENCY=16 so its queue can be filled while the FSM
// is busy with an earlier request.
// ----------------------------------------------------------------------------
module tb_ccip_mem_responder;
    import ccip_mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    t_if_ccip_c0_Tx c0_tx_a, c0_tx_b;
    t_if_ccip_c1_Tx c1_tx_a, c1_tx_b;
    t_if_ccip_Rx    rx_a, rx_b;
    logic           oor_a, align_a, ovf_a;
    logic           oor_b, align_b, ovf_b;

    int err_cnt = 0;
    int chk_cnt = 0;

    ccip_mem_responder u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ccip_c0_tx   (c0_tx_a),
        .ccip_c1_tx   (c1_tx_a),
        .ccip_rx      (rx_a),
        .err_oor      (oor_a),
        .err_align    (align_a),
        .err_overflow (ovf_a)
    );

    ccip_mem_responder #(
        .RD_LATENCY (16)
    ) u_dut_slow (
        .clk          (clk),
        .reset_n      (reset_n),
        .ccip_c0_tx   (c0_tx_b),
        .ccip_c1_tx   (c1_tx_b),
        .ccip_rx      (rx_b),
        .err_oor      (oor_b),
        .err_align    (align_b),
        .err_overflow (ovf_b)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_push_a(input t_ccip_clAddr a, input t_ccip_clLen l, input t_ccip_mdata m);
        c0_tx_a.valid       = 1'b1;
        c0_tx_a.hdr.address = a;
        c0_tx_a.hdr.cl_len  = l;
        c0_tx_a.hdr.mdata   = m;
        step();
        c0_tx_a.valid       = 1'b0;
    endtask

    // Write one line; the ack is due in the cycle after acceptance
    task automatic wr_a(input t_ccip_clAddr a, input t_ccip_mdata m, input t_ccip_clData d);
        c1_tx_a.valid       = 1'b1;
        c1_tx_a.hdr.address = a;
        c1_tx_a.hdr.sop     = 1'b1;
        c1_tx_a.hdr.mdata   = m;
        c1_tx_a.data        = d;
        step();
        c1_tx_a.valid       = 1'b0;
        check("wr_ack_vld", 512'(rx_a.c1.rspValid), 512'(1'b1));
        check("wr_ack_mdata", 512'(rx_a.c1.hdr.mdata), 512'(m));
        check("wr_ack_type", 512'(rx_a.c1.hdr.resp_type), 512'(eRSP_WRLINE));
    endtask

    // Wait (bounded) for a c0 beat; n = cycles waited
    task automatic wait_c0(input bit use_b, input int max_cyc, output int n);
        n = 0;
        while (!(use_b ? rx_b.c0.rspValid : rx_a.c0.rspValid) && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    // Check the current beat on u_dut, then advance one cycle
    task automatic chk_beat_a(input string tag, input int num, input t_ccip_mdata m,
                              input t_ccip_clData d);
        check({tag, "_vld"},   512'(rx_a.c0.rspValid),      512'(1'b1));
        check({tag, "_num"},   512'(rx_a.c0.hdr.cl_num),    512'(num));
        check({tag, "_mdata"}, 512'(rx_a.c0.hdr.mdata),     512'(m));
        check({tag, "_type"},  512'(rx_a.c0.hdr.resp_type), 512'(eRSP_RDLINE));
        check({tag, "_data"},  rx_a.c0.data,                d);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        reset_n = 1'b0;
        c0_tx_a = '0;
        c1_tx_a = '0;
        c0_tx_b = '0;
        c1_tx_b = '0;
        step();
        step();

        // Reset state
        check("rst_c0_vld", 512'(rx_a.c0.rspValid), 512'(1'b0));
        check("rst_c1_vld", 512'(rx_a.c1.rspValid), 512'(1'b0));
        check("rst_c0_alm", 512'(rx_a.c0TxAlmFull), 512'(1'b0));
        check("rst_c1_alm", 512'(rx_a.c1TxAlmFull), 512'(1'b1));
        check("rst_data",   rx_a.c0.data, 512'd0);
        check("rst_errs",   512'({oor_a, align_a, ovf_a}), 512'(3'b000));
        reset_n = 1'b1;
        step();
        check("run_c1_alm", 512'(rx_a.c1TxAlmFull), 512'(1'b0));

        // Single write then single-line read: pop one edge after the push,
        // first beat RD_LATENCY=4 edges after the pop -> 5 cycles after push
        wr_a(42'd5, 16'd3, {64{8'hA5}});
        step();
        check("wr_ack_clear", 512'(rx_a.c1.rspValid), 512'(1'b0));
        rd_push_a(42'd5, eCL_LEN_1, 16'h0011);
        wait_c0(1'b0, 20, n);
        check("rd1_latency", 512'(n), 512'(5));
        chk_beat_a("rd1", 0, 16'h0011, {64{8'hA5}});
        check("rd1_single", 512'(rx_a.c0.rspValid), 512'(1'b0));

        // Four-line burst, lines 8..11 hold 8..11
        for (int i = 8; i < 12; i++) begin
            wr_a(42'(i), 16'(i), 512'(i));
        end
        rd_push_a(42'd8, eCL_LEN_4, 16'h0044);
        wait_c0(1'b0, 20, n);
        check("rd4_latency", 512'(n), 512'(5));
        for (int b = 0; b < 4; b++) begin
            chk_beat_a("rd4", b, 16'h0044, 512'(8 + b));
        end
        check("rd4_end", 512'(rx_a.c0.rspValid), 512'(1'b0));
        check("align_clear", 512'(align_a), 512'(1'b0));

        // Misaligned two-line read at line 3 is still served from lines 3,4
        wr_a(42'd3, 16'd1, 512'h3333);
        wr_a(42'd4, 16'd2, 512'h4444);
        rd_push_a(42'd3, eCL_LEN_2, 16'h0055);
        check("align_set", 512'(align_a), 512'(1'b1));
        wait_c0(1'b0, 20, n);
        chk_beat_a("mis0", 0, 16'h0055, 512'h3333);
        chk_beat_a("mis1", 1, 16'h0055, 512'h4444);

        // Out-of-window read returns zero data; out-of-window write is dropped
        wr_a(42'd0, 16'd4, {16{32'hDEADBEEF}});
        wr_a(42'd1, 16'd5, 512'h1111);
        check("oor_clear", 512'(oor_a), 512'(1'b0));
        rd_push_a(42'd1024, eCL_LEN_1, 16'h0066);
        wait_c0(1'b0, 20, n);
        check("oor_set", 512'(oor_a), 512'(1'b1));
        chk_beat_a("oor", 0, 16'h0066, 512'd0);
        wr_a(42'd1025, 16'd6, {512{1'b1}});
        rd_push_a(42'd1, eCL_LEN_1, 16'h0067);
        wait_c0(1'b0, 20, n);
        chk_beat_a("oor_wr_drop", 0, 16'h0067, 512'h1111);

        // Read/write collision on line 20: beat 0 issues at the 5th edge
        // after the push, which is where the concurrent write is accepted
        wr_a(42'd20, 16'd7, 512'h0BAD);
        wr_a(42'd21, 16'd8, 512'h0021);
        rd_push_a(42'd20, eCL_LEN_2, 16'h0077);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("col_pre", 512'(rx_a.c0.rspValid), 512'(1'b0));
        c1_tx_a.valid       = 1'b1;
        c1_tx_a.hdr.address = 42'd20;
        c1_tx_a.hdr.mdata   = 16'd9;
        c1_tx_a.data        = 512'hC0DE;
        step();
        c1_tx_a.valid       = 1'b0;
        check("col_c1_vld", 512'(rx_a.c1.rspValid), 512'(1'b1));
        chk_beat_a("col0", 0, 16'h0077, 512'h0BAD);
        chk_beat_a("col1", 1, 16'h0077, 512'h0021);
        rd_push_a(42'd20, eCL_LEN_1, 16'h0078);
        wait_c0(1'b0, 20, n);
        chk_beat_a("col_new", 0, 16'h0078, 512'hC0DE);

        // Slow instance: primer is popped at the 2nd edge and holds the FSM
        // for 16+ cycles, so the next 8 pushes fill the 8-deep queue
        c0_tx_b.valid       = 1'b1;
        c0_tx_b.hdr.address = 42'd0;
        c0_tx_b.hdr.cl_len  = eCL_LEN_1;
        c0_tx_b.hdr.mdata   = 16'h0100;
        step();
        for (int i = 0; i < 8; i++) begin
            c0_tx_b.hdr.mdata = 16'(i);
            step();
            if (i == 5) check("alm_before", 512'(rx_b.c0TxAlmFull), 512'(1'b0));
            if (i == 6) check("alm_rise", 512'(rx_b.c0TxAlmFull), 512'(1'b1));
        end
        check("ovf_before", 512'(ovf_b), 512'(1'b0));
        c0_tx_b.hdr.mdata = 16'h0099;
        step();
        c0_tx_b.valid = 1'b0;
        check("ovf_set", 512'(ovf_b), 512'(1'b1));
        for (int k = 0; k < 9; k++) begin
            wait_c0(1'b1, 40, n);
            check("ord_vld", 512'(rx_b.c0.rspValid), 512'(1'b1));
            check("ord_mdata", 512'(rx_b.c0.hdr.mdata),
                  (k == 0) ? 512'h0100 : 512'(k - 1));
            step();
        end
        check("alm_fall", 512'(rx_b.c0TxAlmFull), 512'(1'b0));

        // Reset dropped mid-burst: outputs clear immediately, nothing stale
        rd_push_a(42'd8, eCL_LEN_4, 16'h0088);
        rd_push_a(42'd9, eCL_LEN_1, 16'h0089);
        wait_c0(1'b0, 20, n);
        check("mid_beat0", 512'(rx_a.c0.rspValid), 512'(1'b1));
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_c0_vld",   512'(rx_a.c0.rspValid),  512'(1'b0));
        check("arst_c0_data",  rx_a.c0.data,            512'd0);
        check("arst_c0_mdata", 512'(rx_a.c0.hdr.mdata), 512'(16'h0000));
        check("arst_c1_alm",   512'(rx_a.c1TxAlmFull),  512'(1'b1));
        step();
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rx_a.c0.rspValid) seen++;
        end
        check("no_stale", 512'(seen), 512'(0));
        check("rel_c0_alm", 512'(rx_a.c0TxAlmFull), 512'(1'b0));
        check("rel_c1_alm", 512'(rx_a.c1TxAlmFull), 512'(1'b0));
        check("rel_errs", 512'({oor_a, align_a, ovf_a, ovf_b}), 512'(4'b0000));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
